sonar_scheduler: RTL and testbench

//  Round-robin measurement scheduler for N HC-SR04-style ultrasonic sensors on one shared timebase.
//  Per sensor, in turn: issue the trigger pulse, time the echo in microseconds, publish the result.

---
 rtl/sonar_pkg.sv | 21 ++
 rtl/sonar_scheduler_us_tick_gen.sv | 28 ++
 rtl/sonar_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_sonar_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sonar_pkg.sv
// Shared definitions for the sonar scheduler: FSM encoding, counter widths and
// a small sensor-index helper.
package sonar_pkg;

   localparam int US_W   = 15;
   localparam int HOLD_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_TRIG      = 3'd1,
      ST_WAIT_RISE = 3'd2,
      ST_MEASURE   = 3'd3,
      ST_HOLDOFF   = 3'd4
   } state_t;

   // Round-robin successor of a sensor index over n sensors.
   function automatic logic [2:0] next_sel(input logic [2:0] cur, input int n);
      return (cur == 3'(n - 1)) ? 3'd0 : cur + 3'd1;
   endfunction

endpackage

// File: rtl/sonar_scheduler_us_tick_gen.sv
// Free-running microsecond strobe: us_tick is high for one clk every CLK_DIV clks.
// Used as a clock enable only.
module us_tick_gen #(
   parameter int CLK_DIV = 50
) (
   input  logic clk,
   input  logic rst,
   output logic us_tick
);

   localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] div_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
      end else if (div_cnt == LAST) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   assign us_tick = (div_cnt == LAST);

endmodule

// File: rtl/sonar_scheduler.sv
// Round-robin scheduler for N ultrasonic rangers: trigger, time the echo in us,
// publish the result, then hold off before moving on to the next sensor.
module sonar_scheduler
   import sonar_pkg::*;
#(
   parameter int N_SENS     = 4,
   parameter int CLK_DIV    = 50,
   parameter int TRIG_US    = 10,
   parameter int TIMEOUT_US = 30000,
   parameter int HOLDOFF_US = 60000,
   parameter int NEAR_US    = 1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              Enable,
   input  logic [N_SENS-1:0] Echo,
   output logic [N_SENS-1:0] Trigger,
   output logic              busy,
   output logic [2:0]        sel,
   output logic              meas_valid,
   output logic [2:0]        meas_id,
   output logic [US_W-1:0]   meas_us,
   output logic              meas_to,
   output logic [N_SENS-1:0] near,
   output logic [2:0]        dbg_state
);

   localparam logic [US_W-1:0]   TRIG_LAST = US_W'(TRIG_US - 1);
   localparam logic [US_W-1:0]   TO_LAST   = US_W'(TIMEOUT_US - 1);
   localparam logic [US_W-1:0]   TO_VAL    = US_W'(TIMEOUT_US);
   localparam logic [US_W-1:0]   NEAR_VAL  = US_W'(NEAR_US);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_US - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLDOFF_US);

   state_t              state;
   logic                us_tick;
   logic [US_W-1:0]     us_cnt;
   logic [HOLD_W-1:0]   hold_cnt;
   logic [N_SENS-1:0]   echo_meta, echo_sync, echo_prev;
   logic                echo_now, echo_old, echo_rise, echo_fall;
   logic                pub_fire, pub_to;
   logic [US_W-1:0]     pub_us;
   logic [2:0]          sel_next;

   function automatic logic [N_SENS-1:0] sel_onehot(input logic [2:0] s);
      logic [N_SENS-1:0] oh;
      oh = '0;
      for (int i = 0; i < N_SENS; i++) begin
         if (s == 3'(i)) oh[i] = 1'b1;
      end
      return oh;
   endfunction

   us_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk     (clk),
      .rst     (rst),
      .us_tick (us_tick)
   );

   // echo_prev keeps the whole vector so a change of sel never fakes an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         echo_meta <= '0;
         echo_sync <= '0;
         echo_prev <= '0;
      end else begin
         echo_meta <= Echo;
         echo_sync <= echo_meta;
         echo_prev <= echo_sync;
      end
   end

   always_comb begin
      echo_now = 1'b0;
      echo_old = 1'b0;
      for (int i = 0; i < N_SENS; i++) begin
         if (sel == 3'(i)) begin
            echo_now = echo_sync[i];
            echo_old = echo_prev[i];
         end
      end
   end

   assign echo_rise = echo_now & ~echo_old;
   assign echo_fall = ~echo_now & echo_old;
   assign sel_next  = next_sel(sel, N_SENS);

   // Deciding events for a result; reaching the timeout outranks a coincident fall.
   always_comb begin
      pub_fire = 1'b0;
      pub_to   = 1'b0;
      pub_us   = us_cnt;
      case (state)
         ST_WAIT_RISE: begin
            if (!echo_rise && us_tick && us_cnt == TO_LAST) begin
               pub_fire = 1'b1;
               pub_to   = 1'b1;
               pub_us   = TO_VAL;
            end
         end
         ST_MEASURE: begin
            if (us_tick && us_cnt == TO_LAST) begin
               pub_fire = 1'b1;
               pub_to   = 1'b1;
               pub_us   = TO_VAL;
            end else if (echo_fall) begin
               pub_fire = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Shots launch only on a tick so the trigger lasts exactly TRIG_US ticks.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         sel        <= 3'd0;
         Trigger    <= '0;
         us_cnt     <= '0;
         hold_cnt   <= '0;
         meas_valid <= 1'b0;
         meas_id    <= 3'd0;
         meas_us    <= '0;
         meas_to    <= 1'b0;
         near       <= '0;
      end else begin
         meas_valid <= pub_fire;
         if (pub_fire) begin
            meas_id <= sel;
            meas_us <= pub_us;
            meas_to <= pub_to;
            for (int i = 0; i < N_SENS; i++) begin
               if (sel == 3'(i)) near[i] <= !pub_to && (pub_us < NEAR_VAL);
            end
         end

         if (us_tick && state != ST_IDLE && hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + 1'b1;
         end

         case (state)
            ST_IDLE: begin
               if (Enable && us_tick) begin
                  state    <= ST_TRIG;
                  Trigger  <= sel_onehot(sel);
                  us_cnt   <= '0;
                  hold_cnt <= '0;
               end
            end
            ST_TRIG: begin
               if (us_tick) begin
                  if (us_cnt == TRIG_LAST) begin
                     Trigger <= '0;
                     us_cnt  <= '0;
                     state   <= ST_WAIT_RISE;
                  end else begin
                     us_cnt <= us_cnt + 1'b1;
                  end
               end
            end
            ST_WAIT_RISE: begin
               if (echo_rise) begin
                  us_cnt <= '0;
                  state  <= ST_MEASURE;
               end else if (pub_fire) begin
                  state <= ST_HOLDOFF;
               end else if (us_tick) begin
                  us_cnt <= us_cnt + 1'b1;
               end
            end
            ST_MEASURE: begin
               if (pub_fire) begin
                  state <= ST_HOLDOFF;
               end else if (us_tick) begin
                  us_cnt <= us_cnt + 1'b1;
               end
            end
            ST_HOLDOFF: begin
               if (us_tick && hold_cnt >= HOLD_LAST) begin
                  sel <= sel_next;
                  if (Enable) begin
                     state    <= ST_TRIG;
                     Trigger  <= sel_onehot(sel_next);
                     us_cnt   <= '0;
                     hold_cnt <= '0;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy      = (state != ST_IDLE);
   assign dbg_state = state;

endmodule

// File: tb/tb_sonar_scheduler.sv
// Randomized bench for sonar_scheduler: a sensor driver reacts to the triggers,
// a shot-level model predicts each result and a per-cycle compare checks outputs.
module tb_sonar_scheduler;

   localparam int N       = 4;
   localparam int CLK_DIV = 2;
   localparam int TRIG_US = 10;
   localparam int TO_US   = 200;
   localparam int HOLD_US = 400;
   localparam int NEAR_US = 50;
   localparam int EXP_W   = 19;   // {id[2:0], to, us[14:0]}

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc++;

   logic          Enable = 1'b0;
   logic [N-1:0]  Echo, Trigger, near;
   logic          busy, meas_valid, meas_to;
   logic [2:0]    sel, meas_id, dbg_state;
   logic [14:0]   meas_us;
   logic [N-1:0]  echo_drv   = '0;
   logic [N-1:0]  echo_noise = '0;
   logic [N-1:0]  own_mask   = '0;

   assign Echo = (echo_noise & ~own_mask) | echo_drv;

   sonar_scheduler #(
      .N_SENS(N), .CLK_DIV(CLK_DIV), .TRIG_US(TRIG_US),
      .TIMEOUT_US(TO_US), .HOLDOFF_US(HOLD_US), .NEAR_US(NEAR_US)
   ) dut (
      .clk(clk), .rst(rst), .Enable(Enable), .Echo(Echo), .Trigger(Trigger),
      .busy(busy), .sel(sel), .meas_valid(meas_valid), .meas_id(meas_id),
      .meas_us(meas_us), .meas_to(meas_to), .near(near), .dbg_state(dbg_state)
   );

   // scoreboard state
   int                checks = 0;
   int                failures = 0;
   logic [EXP_W-1:0]  exp_q[$];
   logic [N-1:0]      near_model = '0;
   logic [2:0]        last_id = 3'd0;
   logic              last_to = 1'b0;
   int                exp_sel = 0;
   int                pub_cnt = 0;
   int                pub_cyc = 0;
   int                last_rise = 0;
   bit                chk_en = 1'b0;
   bit                noise_en = 1'b0;
   bit                prev_valid = 1'b0;

   function automatic void chk(string name, longint act, longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   function automatic void chk_rng(string name, longint act, longint lo, longint hi);
      checks++;
      if (act < lo || act > hi) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endfunction

   // per-cycle compare against the shot-level model
   always @(negedge clk) begin
      logic [EXP_W-1:0] e;
      int id;
      if (rst || !chk_en) begin
         prev_valid = 1'b0;
      end else begin
         if (Trigger != '0) begin
            chk("trig_onehot", $countones(Trigger), 1);
            chk("trig_sensor", Trigger, 1 << exp_sel);
            chk("busy_during_trig", busy, 1);
            chk("sel_during_trig", sel, exp_sel);
         end
         if (meas_valid) begin
            chk("valid_one_clk", prev_valid, 0);
            chk("result_pending", exp_q.size() > 0, 1);
            chk("busy_on_publish", busy, 1);
            if (exp_q.size() > 0) begin
               e  = exp_q.pop_front();
               id = int'(e[18:16]);
               chk("meas_id", meas_id, e[18:16]);
               chk("meas_to", meas_to, e[15]);
               if (e[15]) chk("meas_us_timeout", meas_us, e[14:0]);
               else       chk_rng("meas_us", meas_us, e[14:0] - 1, e[14:0] + 1);
               near_model[id] = !e[15] && (e[14:0] < NEAR_US);
               last_id = e[18:16];
               last_to = e[15];
            end
            pub_cnt++;
            pub_cyc = cyc;
         end else begin
            chk("hold_meas_id", meas_id, last_id);
            chk("hold_meas_to", meas_to, last_to);
         end
         chk("near", near, near_model);
         prev_valid = meas_valid;
      end
   end

   // echo activity on sensors that do not own the bus must be ignored
   initial begin
      forever begin
         @(negedge clk);
         if (noise_en && $urandom_range(0, 7) == 0) echo_noise = N'($urandom);
      end
   end

   // driver tasks
   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_trig(output int s, output bit ok);
      ok = 1'b0;
      s  = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (Trigger != '0) begin
            ok = 1'b1;
            break;
         end
      end
      for (int k = 0; k < N; k++) if (Trigger[k]) s = k;
   endtask

   // kind: 0 = echo after d us lasting w us, 1 = no echo, 2 = echo stuck high
   task automatic run_shot(input int kind, input int d, input int w, input bit drop_en, input bit spc);
      int s, width, p0, lim, t_fall, c_edge;
      bit ok, to_exp;
      int us_exp;
      own_mask = N'(1 << exp_sel);
      if (kind == 2) echo_drv = own_mask;
      wait_trig(s, ok);
      chk("trigger_seen", ok, 1);
      if (!ok) return;
      chk("shot_sensor", s, exp_sel);
      if (spc) chk("trigger_spacing_clks", cyc - last_rise, HOLD_US * CLK_DIV);
      last_rise = cyc;
      width = 0;
      while (Trigger != '0 && width < 100) begin
         width++;
         @(negedge clk);
      end
      chk("trigger_width_clks", width, TRIG_US * CLK_DIV);
      t_fall = cyc;
      if (kind == 0 && w < TO_US) begin
         to_exp = 1'b0;
         us_exp = w;
      end else begin
         to_exp = 1'b1;
         us_exp = TO_US;
      end
      exp_q.push_back({3'(s), to_exp, 15'(us_exp)});
      p0 = pub_cnt;
      c_edge = 0;
      if (kind == 0) begin
         wait_cycles(d * CLK_DIV);
         echo_drv = own_mask;
         c_edge = cyc;
         if (drop_en) begin
            wait_cycles(10);
            Enable = 1'b0;
            wait_cycles(w * CLK_DIV - 10);
         end else begin
            wait_cycles(w * CLK_DIV);
         end
         echo_drv = '0;
         if (w < TO_US) c_edge = cyc;
      end
      lim = 0;
      while (pub_cnt == p0 && lim < 1000) begin
         lim++;
         @(negedge clk);
      end
      chk("publish_count", pub_cnt - p0, 1);
      if (kind != 0)        chk_rng("timeout_latency", pub_cyc - t_fall, 399, 401);
      else if (w < TO_US)   chk_rng("fall_latency", pub_cyc - c_edge, 2, 4);
      else                  chk_rng("width_timeout_latency", pub_cyc - c_edge, 399, 405);
      if (kind == 2) echo_drv = '0;
      exp_sel = (exp_sel + 1) % N;
   endtask

   task automatic reset_mid_measure();
      int s;
      bit ok;
      own_mask = N'(1 << exp_sel);
      wait_trig(s, ok);
      chk("trigger_seen_before_reset", ok, 1);
      wait_cycles(TRIG_US * CLK_DIV + 10);
      echo_drv = own_mask;
      wait_cycles(40);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_trigger", Trigger, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sel", sel, 0);
      chk("rst_meas_valid", meas_valid, 0);
      chk("rst_meas_id", meas_id, 0);
      chk("rst_meas_us", meas_us, 0);
      chk("rst_meas_to", meas_to, 0);
      chk("rst_near", near, 0);
      echo_drv = '0;
      exp_q.delete();
      near_model = '0;
      last_id = 3'd0;
      last_to = 1'b0;
      exp_sel = 0;
      wait_cycles(3);
      rst = 1'b0;
   endtask

   initial begin
      #800000;
      failures++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int kind, d, w, trig_cnt;
      wait_cycles(4);
      chk("reset_trigger", Trigger, 0);
      chk("reset_busy", busy, 0);
      chk("reset_sel", sel, 0);
      chk("reset_meas_valid", meas_valid, 0);
      chk("reset_meas_us", meas_us, 0);
      chk("reset_near", near, 0);
      chk("reset_state", dbg_state, 0);
      rst = 1'b0;
      chk_en = 1'b1;
      noise_en = 1'b1;
      Enable = 1'b1;

      // directed round: normal, no echo, stuck echo, normal
      run_shot(0, 5, 80, 0, 0);
      chk_rng("s0_meas_us_literal", meas_us, 79, 81);
      chk("s0_meas_to_literal", meas_to, 0);
      run_shot(1, 0, 0, 0, 1);
      chk("s1_meas_us_literal", meas_us, 200);
      chk("s1_meas_to_literal", meas_to, 1);
      run_shot(2, 0, 0, 0, 1);
      chk("s2_stuck_id_literal", meas_id, 2);
      run_shot(0, 10, 120, 0, 1);
      // second round: over-long echo, near widths, wrap
      run_shot(0, 3, 250, 0, 1);
      run_shot(0, 5, 40, 0, 1);
      run_shot(0, 6, 30, 0, 1);
      chk("near_after_round2_literal", near, 4'b0110);
      run_shot(0, 4, 60, 0, 1);

      for (int i = 0; i < 12; i++) begin
         kind = $urandom_range(0, 9);
         d = $urandom_range(1, 60);
         if (kind <= 6) begin
            do w = $urandom_range(2, 180); while (w >= NEAR_US - 2 && w <= NEAR_US + 2);
            run_shot(0, d, w, 0, 1);
         end else if (kind == 7) begin
            run_shot(1, 0, 0, 0, 1);
         end else if (kind == 8) begin
            run_shot(2, 0, 0, 0, 1);
         end else begin
            w = $urandom_range(205, 260);
            run_shot(0, d, w, 0, 1);
         end
      end

      // Enable dropped mid-measure: result still arrives, then idle
      run_shot(0, 5, 100, 1, 1);
      trig_cnt = 0;
      for (int i = 0; i < 700; i++) begin
         @(negedge clk);
         if (Trigger != '0) trig_cnt++;
      end
      chk("no_trigger_while_disabled", trig_cnt, 0);
      chk("idle_after_holdoff", busy, 0);
      chk("sel_advanced_while_idle", sel, exp_sel);
      Enable = 1'b1;
      run_shot(0, 8, 70, 0, 0);

      // asynchronous reset in the middle of a measurement
      reset_mid_measure();
      run_shot(0, 5, 45, 0, 0);
      chk("near_after_reset_literal", near, 4'b0001);

      chk_en = 1'b0;
      noise_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
